// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, the hard-wired zero register index and the write-port priority enum.
package rf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO = 0;
    typedef enum logic {PRI_A, PRI_B} pri_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits (issue sets, write-back clears, set wins) and registered popcount.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      iss_en_i,
    input  logic [ADDR_W-1:0]         iss_addr_i,
    input  logic                      wa_en_i,
    input  logic [ADDR_W-1:0]         wa_addr_i,
    input  logic                      wb_en_i,
    input  logic [ADDR_W-1:0]         wb_addr_i,
    output logic [(2**ADDR_W)-1:0]    pending_o,
    output logic [ADDR_W:0]           busy_cnt_o
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DEPTH-1:0] pending_q, pending_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    always_comb begin
        pending_d = pending_q;
        for (int r = 1; r < DEPTH; r++) begin
            if ((wa_en_i && wa_addr_i == ADDR_W'(r)) || (wb_en_i && wb_addr_i == ADDR_W'(r)))
                pending_d[r] = 1'b0;
            if (iss_en_i && iss_addr_i == ADDR_W'(r))
                pending_d[r] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
        cnt_d = '0;
        for (int r = 0; r < DEPTH; r++)
            cnt_d = cnt_d + (ADDR_W+1)'(pending_d[r]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end
    assign pending_o  = pending_q;
    assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read, dual write-back register file with pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic                  wa_en_i,
    input  logic [ADDR_W-1:0]     wa_addr_i,
    input  logic [DATA_W-1:0]     wa_data_i,
    input  logic                  wb_en_i,
    input  logic [ADDR_W-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic                  iss_en_i,
    input  logic [ADDR_W-1:0]     iss_addr_i,
    output logic [ADDR_W:0]       busy_cnt_o
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wa_wr, wb_wr;
    assign wa_wr = wa_en_i && wa_addr_i != ADDR_W'(REG_ZERO);
    assign wb_wr = wb_en_i && wb_addr_i != ADDR_W'(REG_ZERO);
    // Port B applied first so port A overwrites it on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wb_wr) regs_d[wb_addr_i] = wb_data_i;
        if (wa_wr) regs_d[wa_addr_i] = wa_data_i;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end
    rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wa_en_i    (wa_en_i),
        .wa_addr_i  (wa_addr_i),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .pending_o  (pending),
        .busy_cnt_o (busy_cnt_o)
    );
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr_i[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit_a, hit_b;
        pri_e pri;
        assign hit_a = wa_wr && wa_addr_i == a;
        assign hit_b = wb_wr && wb_addr_i == a;
        assign pri   = hit_a ? PRI_A : PRI_B;
        assign rd_data_o[g*DATA_W +: DATA_W] = !(hit_a || hit_b) ? regs_q[a] :
                                               pri == PRI_A ? wa_data_i : wb_data_i;
        // A forwarded write retires the producer unless a new one issues on top of it.
        assign rd_busy_o[g] = (hit_a || hit_b) ? (iss_en_i && iss_addr_i == a && pending[a]) : pending[a];
`else
        assign rd_data_o[g*DATA_W +: DATA_W] = regs_q[a];
        assign rd_busy_o[g] = pending[a];
`endif
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp (both REGFILE_BYPASS_EN builds).
module tb_reg_file_mp;
    logic        clk = 0;
    logic        rst_n;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic        wa_en_i, wb_en_i, iss_en_i;
    logic [4:0]  wa_addr_i, wb_addr_i, iss_addr_i;
    logic [31:0] wa_data_i, wb_data_i;
    logic [5:0]  busy_cnt_o;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wa_en_i    (wa_en_i),
        .wa_addr_i  (wa_addr_i),
        .wa_data_i  (wa_data_i),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .busy_cnt_o (busy_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en_i = 0; wb_en_i = 0; iss_en_i = 0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
        #1;
    endtask

    initial begin
        rst_n = 0; rd_addr_i = '0;
        wa_addr_i = '0; wb_addr_i = '0; iss_addr_i = '0;
        wa_data_i = '0; wb_data_i = '0;
        idle();
        step(); step();
        rst_n = 1;
        rd(0, 0);
        chk("reset_cnt", 64'(busy_cnt_o), 64'd0);
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            chk("reset_data0", 64'(rd_data_o[31:0]), 64'd0);
            chk("reset_data1", 64'(rd_data_o[63:32]), 64'd0);
            chk("reset_busy", 64'(rd_busy_o), 64'd0);
        end

        // Same-address dual write: port A wins
        wa_en_i = 1; wa_addr_i = 5; wa_data_i = 32'hDEADBEEF;
        wb_en_i = 1; wb_addr_i = 5; wb_data_i = 32'h12345678;
        step(); idle();
        rd(5, 5);
        chk("pri_a_p0", 64'(rd_data_o[31:0]), 64'hDEADBEEF);
        chk("pri_a_p1", 64'(rd_data_o[63:32]), 64'hDEADBEEF);
        wb_en_i = 1; wb_addr_i = 6; wb_data_i = 32'h12345678;
        step(); idle();
        rd(5, 6);
        chk("wb_only", 64'(rd_data_o[63:32]), 64'h12345678);

        // Register zero
        wa_en_i = 1; wa_addr_i = 0; wa_data_i = 32'hFFFFFFFF;
        iss_en_i = 1; iss_addr_i = 0;
        step(); idle();
        rd(0, 0);
        chk("r0_data", 64'(rd_data_o[31:0]), 64'd0);
        chk("r0_busy", 64'(rd_busy_o), 64'd0);
        chk("r0_cnt", 64'(busy_cnt_o), 64'd0);

        // Scoreboard
        iss_en_i = 1; iss_addr_i = 7; step();
        chk("cnt_1", 64'(busy_cnt_o), 64'd1);
        iss_addr_i = 8; step();
        chk("cnt_2", 64'(busy_cnt_o), 64'd2);
        iss_addr_i = 9; step(); idle();
        chk("cnt_3", 64'(busy_cnt_o), 64'd3);
        rd(7, 8);
        chk("busy_7_8", 64'(rd_busy_o), 64'd3);
        wb_en_i = 1; wb_addr_i = 8; wb_data_i = 32'h88;
        step(); idle();
        rd(7, 8);
        chk("clr8_cnt", 64'(busy_cnt_o), 64'd2);
        chk("clr8_busy", 64'(rd_busy_o), 64'b01);
        chk("clr8_data", 64'(rd_data_o[63:32]), 64'h88);
        iss_en_i = 1; iss_addr_i = 7;
        wa_en_i = 1; wa_addr_i = 7; wa_data_i = 32'h77;
        step(); idle();
        rd(7, 9);
        chk("set_wins_busy", 64'(rd_busy_o), 64'b11);
        chk("set_wins_cnt", 64'(busy_cnt_o), 64'd2);
        chk("set_wins_data", 64'(rd_data_o[31:0]), 64'h77);

        // Write-to-read latency and bypass
        rd(3, 9);
        wa_en_i = 1; wa_addr_i = 3; wa_data_i = 32'hA5A5A5A5;
        wb_en_i = 1; wb_addr_i = 9; wb_data_i = 32'h99;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data3", 64'(rd_data_o[31:0]), 64'hA5A5A5A5);
        chk("byp_data9", 64'(rd_data_o[63:32]), 64'h99);
        chk("byp_busy", 64'(rd_busy_o), 64'b00);
`else
        chk("nobyp_data3", 64'(rd_data_o[31:0]), 64'd0);
        chk("nobyp_data9", 64'(rd_data_o[63:32]), 64'd0);
        chk("nobyp_busy", 64'(rd_busy_o), 64'b10);
`endif
        step(); idle();
        rd(3, 9);
        chk("lat_data3", 64'(rd_data_o[31:0]), 64'hA5A5A5A5);
        chk("lat_data9", 64'(rd_data_o[63:32]), 64'h99);
        chk("lat_busy", 64'(rd_busy_o), 64'b00);
        chk("lat_cnt", 64'(busy_cnt_o), 64'd1);

        // Reset mid-stream with four pending registers and active writes
        iss_en_i = 1; iss_addr_i = 10; step();
        iss_addr_i = 11; step();
        iss_addr_i = 12; step(); idle();
        chk("pre_rst_cnt", 64'(busy_cnt_o), 64'd4);
        rst_n = 0;
        wa_en_i = 1; wa_addr_i = 13; wa_data_i = 32'h1313;
        wb_en_i = 1; wb_addr_i = 14; wb_data_i = 32'h1414;
        iss_en_i = 1; iss_addr_i = 15;
        step(); idle();
        rst_n = 1;
        rd(13, 14);
        chk("rst_cnt", 64'(busy_cnt_o), 64'd0);
        chk("rst_wr_drop", rd_data_o, 64'd0);
        rd(7, 15);
        chk("rst_busy", 64'(rd_busy_o), 64'd0);
        rd(5, 3);
        chk("rst_regs", rd_data_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
